// File: rtl/maze_ram_pkg.sv
// Shared types and defaults for the maze label RAM controller.
// Imported by the interface, the clear sweep and the controller.
package maze_ram_pkg;

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_st_e;

  localparam int ADDR_W_DEF  = 7;
  localparam int DATA_W_DEF  = 8;
  localparam int CLR_VAL_DEF = 0;
  localparam int LABEL_MAX   = (1 << DATA_W_DEF) - 1;

endpackage

// File: rtl/maze_ram_ctrl_if.sv
// Client-side and RAM-side bundle of the maze label RAM controller.
// master = engines/RAM environment, slave = controller.
interface maze_ram_ctrl_if
  import maze_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              clr_req;
  logic              bc_mode;
  logic              wen_cgr;
  logic              wen_sqg;
  logic [ADDR_W-1:0] bc_rd_addr;
  logic [ADDR_W-1:0] bc_wr_addr;
  logic [ADDR_W-1:0] xy;
  logic [DATA_W-1:0] mlxy;
  logic [DATA_W-1:0] ml1xy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic              clr_busy;
  logic              clr_done;
  logic              proto_err;
  logic              sat_flag;

  modport master (
    output clr_req, bc_mode, wen_cgr, wen_sqg,
    output bc_rd_addr, bc_wr_addr, xy,
    output mlxy, ml1xy,
    input  wr_en, wr_addr, wr_data,
    input  rd_addr, rd_valid,
    input  clr_busy, clr_done,
    input  proto_err, sat_flag
  );

  modport slave (
    input  clr_req, bc_mode, wen_cgr, wen_sqg,
    input  bc_rd_addr, bc_wr_addr, xy,
    input  mlxy, ml1xy,
    output wr_en, wr_addr, wr_data,
    output rd_addr, rd_valid,
    output clr_busy, clr_done,
    output proto_err, sat_flag
  );

endinterface

// File: rtl/ram_clr_sweep.sv
// Full-RAM clear sweep: IDLE/CLEAR state, address counter, busy/done.
// clr_wr/clr_addr are next-cycle values so the caller can register them.
module ram_clr_sweep
  import maze_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output clr_st_e           st,
  output logic              clr_wr,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_busy,
  output logic              clr_done
);

  clr_st_e           st_q, st_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              last;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    last  = (cnt_q == '1);
    unique case (st_q)
      IDLE: begin
        if (start) begin
          st_d  = CLEAR;
          cnt_d = '0;
        end
      end
      CLEAR: begin
        if (last) begin
          st_d  = IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: st_d = IDLE;
    endcase
    clr_wr = (st_d == CLEAR);
    done_d = clr_wr && (cnt_d == '1);
  end

  assign st       = st_q;
  assign clr_addr = cnt_d;
  assign clr_busy = (st_q == CLEAR);
  assign clr_done = done_q;

endmodule

// File: rtl/maze_ram_ctrl.sv
// Label RAM controller: mode muxing, clear sweep, registered RAM side.
// Define MAZE_RAM_CTRL_SAT_EN to saturate the label increment.
module maze_ram_ctrl
  import maze_ram_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CLR_VAL = CLR_VAL_DEF
) (
  input logic            CLK,
  input logic            RST,
  maze_ram_ctrl_if.slave bus
);

  clr_st_e           st;
  logic              start;
  logic              clr_wr;
  logic [ADDR_W-1:0] clr_addr;
  logic              idle;
  logic              sel_wen;
  logic              oth_wen;
  logic [DATA_W-1:0] inc;
  logic              inc_sat;

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_iss_q, rd_iss_d;
  logic              rd_valid_q;
  logic              err_q, err_d;
  logic              sat_q, sat_d;

  ram_clr_sweep #(.ADDR_W(ADDR_W)) u_sweep (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .st       (st),
    .clr_wr   (clr_wr),
    .clr_addr (clr_addr),
    .clr_busy (bus.clr_busy),
    .clr_done (bus.clr_done)
  );

`ifdef MAZE_RAM_CTRL_SAT_EN
  assign inc_sat = (bus.mlxy == '1);
  assign inc     = inc_sat ? bus.mlxy
                           : bus.mlxy + DATA_W'(1);
`else
  assign inc_sat = 1'b0;
  assign inc     = bus.mlxy + DATA_W'(1);
`endif

  assign idle    = (st == IDLE);
  assign sel_wen = bus.bc_mode ? bus.wen_cgr : bus.wen_sqg;
  assign oth_wen = bus.bc_mode ? bus.wen_sqg : bus.wen_cgr;

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    rd_iss_d  = idle;
    err_d     = err_q;
    sat_d     = 1'b0;
    start     = 1'b0;
    if (idle) begin
      rd_addr_d = bus.bc_mode ? bus.xy : bus.bc_rd_addr;
      if (bus.clr_req) begin
        // accepted clear wipes the flag unless this cycle re-offends
        start = 1'b1;
        err_d = bus.wen_cgr | bus.wen_sqg;
      end else begin
        if (oth_wen) err_d = 1'b1;
        if (sel_wen) begin
          wr_en_d = 1'b1;
          if (bus.bc_mode) begin
            wr_addr_d = bus.xy;
            wr_data_d = inc;
            sat_d     = inc_sat;
          end else begin
            wr_addr_d = bus.bc_wr_addr;
            wr_data_d = bus.ml1xy;
          end
        end
      end
    end else if (bus.wen_cgr | bus.wen_sqg) begin
      err_d = 1'b1;
    end
    if (clr_wr) begin
      wr_en_d   = 1'b1;
      wr_addr_d = clr_addr;
      wr_data_d = DATA_W'(CLR_VAL);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_addr_q  <= '0;
      rd_iss_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_addr_q  <= rd_addr_d;
      rd_iss_q   <= rd_iss_d;
      rd_valid_q <= rd_iss_q;
      err_q      <= err_d;
      sat_q      <= sat_d;
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.proto_err = err_q;
  assign bus.sat_flag  = sat_q;

endmodule

// File: tb/tb_maze_ram_ctrl.sv
// Randomised bench for maze_ram_ctrl against a cycle-level reference.
// Honours MAZE_RAM_CTRL_SAT_EN the same way as the design.
module tb_maze_ram_ctrl;
  import maze_ram_pkg::*;

  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int LMAX  = (1 << DW) - 1;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  maze_ram_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  maze_ram_ctrl #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .CLR_VAL (0)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_run  = 0;
  int n_fail = 0;

  // reference state: sweep position, sticky error, read history
  bit m_clr;
  int m_pos;
  bit m_err;
  bit m_iss;
  int m_rd;
  bit e_wen, e_sat, e_done, e_valid;
  int e_wa, e_wd;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv(bit clr, bit mode, bit cgr, bit sqg,
                     int x, int ra, int wa, int ml, int ml1);
    bus.clr_req    = clr;
    bus.bc_mode    = mode;
    bus.wen_cgr    = cgr;
    bus.wen_sqg    = sqg;
    bus.xy         = AW'(x);
    bus.bc_rd_addr = AW'(ra);
    bus.bc_wr_addr = AW'(wa);
    bus.mlxy       = DW'(ml);
    bus.ml1xy      = DW'(ml1);
  endtask

  task automatic model_reset();
    m_clr = 0;
    m_pos = 0;
    m_err = 0;
    m_iss = 0;
    m_rd  = 0;
  endtask

  task automatic model_step();
    bit idle;
    bit sel, oth;
    int ml;
    idle   = !m_clr;
    e_wen  = 0;
    e_sat  = 0;
    e_done = 0;
    e_valid = m_iss;
    m_iss  = idle;
    ml     = int'(bus.mlxy);
    if (idle) m_rd = bus.bc_mode ? int'(bus.xy) : int'(bus.bc_rd_addr);
    if (idle && bus.clr_req) begin
      m_clr  = 1;
      m_pos  = 0;
      m_err  = bus.wen_cgr | bus.wen_sqg;
      e_wen  = 1;
      e_wa   = 0;
      e_wd   = 0;
      e_done = (DEPTH == 1);
    end else if (idle) begin
      sel = bus.bc_mode ? bus.wen_cgr : bus.wen_sqg;
      oth = bus.bc_mode ? bus.wen_sqg : bus.wen_cgr;
      if (oth) m_err = 1;
      if (sel) begin
        e_wen = 1;
        if (bus.bc_mode) begin
          e_wa = int'(bus.xy);
`ifdef MAZE_RAM_CTRL_SAT_EN
          e_wd  = (ml == LMAX) ? LMAX : ml + 1;
          e_sat = (ml == LMAX);
`else
          e_wd = (ml + 1) % (LMAX + 1);
`endif
        end else begin
          e_wa = int'(bus.bc_wr_addr);
          e_wd = int'(bus.ml1xy);
        end
      end
    end else begin
      if (bus.wen_cgr || bus.wen_sqg) m_err = 1;
      if (m_pos == DEPTH - 1) begin
        m_clr = 0;
      end else begin
        m_pos  = m_pos + 1;
        e_wen  = 1;
        e_wa   = m_pos;
        e_wd   = 0;
        e_done = (m_pos == DEPTH - 1);
      end
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_step();
    #1;
    chk("wr_en", bus.wr_en, e_wen);
    if (e_wen) begin
      chk("wr_addr", bus.wr_addr, e_wa);
      chk("wr_data", bus.wr_data, e_wd);
    end
    chk("rd_addr", bus.rd_addr, m_rd);
    chk("rd_valid", bus.rd_valid, e_valid);
    chk("clr_busy", bus.clr_busy, m_clr);
    chk("clr_done", bus.clr_done, e_done);
    chk("proto_err", bus.proto_err, m_err);
    chk("sat_flag", bus.sat_flag, e_sat);
    @(negedge CLK);
  endtask

  task automatic rst_pulse();
    RST = 1'b1;
    #1;
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_busy", bus.clr_busy, 0);
    chk("rst_done", bus.clr_done, 0);
    chk("rst_err", bus.proto_err, 0);
    chk("rst_sat", bus.sat_flag, 0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic idle_n(int n);
    for (int i = 0; i < n; i++) begin
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc();
    end
  endtask

  task automatic wait_pos(int pos);
    int k;
    k = 0;
    while (!(m_clr && m_pos == pos) && k < 2 * DEPTH) begin
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc();
      k++;
    end
    if (k >= 2 * DEPTH) chk("sweep_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (m_clr && k < 2 * DEPTH) begin
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc();
      k++;
    end
    if (k >= 2 * DEPTH) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    rst_pulse();

    // full sweep from reset
    idle_n(4);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    wait_idle();
    idle_n(2);

    // mode 1 increment write, then read valid two cycles on
    drv(0, 1, 1, 0, 'h15, 0, 0, 'h07, 0);
    cyc();
    idle_n(2);

    // mode 0 write-back with stray CGR strobe
    drv(0, 0, 1, 1, 0, 'h22, 'h40, 0, 'h33);
    cyc();
    idle_n(1);

    // all-ones label
    drv(0, 1, 1, 0, 'h03, 0, 0, 'hFF, 0);
    cyc();
    idle_n(1);

    // strobe dropped mid-sweep, later clear wipes the error
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    wait_pos(10);
    drv(0, 0, 0, 1, 0, 0, 'h11, 0, 'h5A);
    cyc();
    wait_idle();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();

    // reset mid-sweep, then immediate client write
    wait_pos(50);
    rst_pulse();
    drv(0, 1, 1, 0, 'h2A, 0, 0, 'h10, 0);
    cyc();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      int ml;
      ml = ($urandom_range(0, 7) == 0) ? LMAX : int'($urandom_range(0, LMAX));
      drv($urandom_range(0, 99) == 0,
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)),
          int'($urandom_range(0, DEPTH - 1)),
          int'($urandom_range(0, DEPTH - 1)),
          int'($urandom_range(0, DEPTH - 1)),
          ml,
          int'($urandom_range(0, LMAX)));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/maze_ram_ctrl.md
# maze_ram_ctrl

Parametrised controller sitting between the maze-expansion engines (breadth-expansion CGR, sequence-generator SQG) and the single-port-write/single-port-read label RAM. It muxes write and read addresses/data per mode, performs a self-timed full-RAM clear sweep with a request/busy/done handshake, and registers all RAM-side outputs. It flags protocol violations and, when configured, saturates the label increment.

## Interface
- ADDR_W, 7, RAM address width; DEPTH = 2**ADDR_W
- DATA_W, 8, label width
- CLR_VAL, 0, value written during clear sweep
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- clr_req  in  1  single-cycle clear request
- bc_mode  in  1  1 = breadth-expansion mode, 0 = sequence/write-back mode
- wen_cgr  in  1  CGR write strobe
- wen_sqg  in  1  SQG write strobe
- bc_rd_addr  in  ADDR_W  read address, mode 0
- bc_wr_addr  in  ADDR_W  write address, mode 0
- xy  in  ADDR_W  read and write address, mode 1
- mlxy  in  DATA_W  current label, mode 1 source
- ml1xy  in  DATA_W  write-back label, mode 0 source
- wr_en  out  1  RAM write enable
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  DATA_W  RAM write data
- rd_addr  out  ADDR_W  RAM read address
- rd_valid  out  1  RAM read data valid this cycle
- clr_busy  out  1  clear sweep in progress
- clr_done  out  1  one-cycle pulse, last clear write issued
- proto_err  out  1  sticky protocol-violation flag
- sat_flag  out  1  one-cycle pulse, increment saturated

## Operation
- States: IDLE, CLEAR. Reset -> IDLE; all outputs 0, sweep counter 0.
- IDLE, bc_mode=1: wen_cgr -> write addr xy, data mlxy+1; read addr xy. wen_sqg ignored, sets proto_err.
- IDLE, bc_mode=0: wen_sqg -> write addr bc_wr_addr, data ml1xy; read addr bc_rd_addr. wen_cgr ignored, sets proto_err.
- Both strobes high: selected-mode strobe writes; other sets proto_err.
- IDLE + clr_req -> CLEAR. Same-cycle write strobes dropped, set proto_err.
- CLEAR: counter 0..DEPTH-1, one write per cycle, data CLR_VAL; clr_busy=1; all write strobes dropped (each sets proto_err); clr_req ignored.
- Counter reaching DEPTH-1: clr_done pulses with that write; next state IDLE; counter returns 0; clr_busy falls.
- proto_err cleared only by RST or by accepted clr_req.
- Increment arithmetic: DATA_W-bit; behaviour at all-ones per Configuration.
- RST mid-sweep: immediate abort, IDLE, no clr_done.

## Timing
- Write path: strobe/inputs at cycle N -> wr_en/wr_addr/wr_data at N+1 (registered).
- Read path: rd_addr registered, updates every IDLE cycle (N -> N+1); RAM read latency 1; rd_valid at N+2 for each IDLE-cycle address; rd_valid 0 during CLEAR and at N+2 following any CLEAR cycle.
- clr_req at N -> clr_busy=1 and first write (addr 0) at N+1; last write (addr DEPTH-1) and clr_done at N+DEPTH; clr_busy=0 at N+DEPTH+1; client writes accepted from cycle N+DEPTH+1.
- sat_flag aligned with the wr_en cycle of the saturated write.
- Throughput: one write and one read per cycle.

## Configuration
- MAZE_RAM_CTRL_SAT_EN defined: mlxy = 2**DATA_W-1 writes 2**DATA_W-1, sat_flag pulses.
- Undefined: mlxy+1 wraps to 0; sat_flag tied 0.

## Structure
- Package maze_ram_pkg: state enum (IDLE, CLEAR), CLR_VAL default, label max constant.
- Sub-module ram_clr_sweep: counter, clr_busy, clr_done, last-address detect; controller owns muxing, registers, error flags.

## Test plan
- Reset, then clr_req at cycle 5 (defaults) -> wr_en addr 0..127 data 0 cycles 6..133, clr_done at 133 only, clr_busy 0 at 134.
- bc_mode=1, xy=0x15, mlxy=0x07, wen_cgr -> next cycle wr_addr 0x15, wr_data 0x08; rd_addr 0x15; rd_valid two cycles after.
- bc_mode=0, bc_wr_addr=0x40, ml1xy=0x33, wen_sqg -> wr_addr 0x40, wr_data 0x33; wen_cgr same cycle sets proto_err, no extra write.
- mlxy=0xFF, wen_cgr: SAT_EN -> wr_data 0xFF, sat_flag 1; without -> wr_data 0x00, sat_flag 0.
- wen_sqg during sweep at addr 10 -> write dropped, proto_err 1, sweep continues; next clr_req clears proto_err.
- RST at sweep addr 50 -> all outputs 0, no clr_done; subsequent writes accepted immediately.
